// File: rtl/gearbox_66to32_if.sv
// Block-in / word-out bus between the 64b/66b scrambler, the TX gearbox and the serializer.
// master = scrambler/serializer side, slave = gearbox.
interface gearbox_66to32_if;
  logic [1:0]  sync_hdr;
  logic [63:0] data_scrambled;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;

  modport master (
    output sync_hdr, data_scrambled, in_valid,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  sync_hdr, data_scrambled, in_valid,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/gearbox_66to32.sv
// TX gearbox: packs 66-bit blocks {payload, sync header} into a continuous 32-bit
// line word stream, LSB first, with in_ready backpressure and an illegal-header counter.
module gearbox_66to32 #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  gearbox_66to32_if.slave      gb,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt
);

  logic [127:0]         sbuf_p0;
  logic [7:0]           cnt_p0;
  logic [31:0]          word_p1;
  logic                 vld_p1;
  logic [ERR_CNT_W-1:0] err_p1;

  logic                 emit;
  logic [7:0]           rem;
  logic                 accept;
  logic                 hdr_bad;
  logic [65:0]          blk;
  logic [127:0]         sbuf_nxt;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Decisions on the current fill level; the outgoing word leaves before the new block lands.
  always_comb begin
    emit     = (cnt_p0 >= 8'd32);
    rem      = emit ? (cnt_p0 - 8'd32) : cnt_p0;
    accept   = gb.in_valid && (rem <= 8'd62);
    hdr_bad  = (gb.sync_hdr[0] == gb.sync_hdr[1]);
    blk      = {gb.data_scrambled, gb.sync_hdr};
    sbuf_nxt = emit ? (sbuf_p0 >> 32) : sbuf_p0;
    if (accept) begin
      // Bits above the fill level are always zero, so OR-ing the block in is an insert.
      sbuf_nxt = sbuf_nxt | ({62'd0, blk} << rem);
    end
  end

  assign gb.in_ready  = (rem <= 8'd62);
  assign gb.out_data  = word_p1;
  assign gb.out_valid = vld_p1;
  assign hdr_err_cnt  = err_p1;

  // Stage boundary: buffer/fill level update and registered line word.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sbuf_p0 <= '0;
      cnt_p0  <= '0;
      word_p1 <= '0;
      vld_p1  <= 1'b0;
      err_p1  <= '0;
    end else begin
      sbuf_p0 <= sbuf_nxt;
      cnt_p0  <= accept ? (rem + 8'd66) : rem;
      vld_p1  <= emit;
      if (emit) begin
        word_p1 <= sbuf_p0[31:0];
      end
      if (accept && hdr_bad) begin
        err_p1 <= sat_inc(err_p1);
      end
    end
  end

endmodule

// File: doc/gearbox_66to32.md
Name: gearbox_66to32

Overview:
- TX gearbox directly downstream of the 64b/66b scrambler.
- Takes one 66-bit block per accepted transfer: a 2-bit sync header plus the 64-bit scrambled payload.
- Emits a continuous 32-bit serializer-facing word stream, least-significant bit first on the line.
- Provides backpressure to the scrambler via in_ready and counts illegal sync headers.

Parameters:
- ERR_CNT_W, 8, width of the saturating invalid-header counter.

Ports:
- CLK  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately; deassertion is synchronous to CLK externally.
- sync_hdr  input  2  sync header of the block; legal values are 2'b01 (data) and 2'b10 (control).
- data_scrambled  input  64  scrambled payload from the scrambler.
- in_valid  input  1  block present on sync_hdr/data_scrambled.
- in_ready  output  1  gearbox can take the block this cycle (combinational from internal count).
- out_data  output  32  line word; bit 0 is transmitted first.
- out_valid  output  1  out_data holds a valid word this cycle.
- hdr_err_cnt  output  ERR_CNT_W  saturating count of accepted blocks with sync_hdr 00 or 11.

Behaviour:
- Line bit order:
  - Block vector B[65:0] = {data_scrambled, sync_hdr}.
  - sync_hdr[0] is the first bit on the line, then sync_hdr[1], then data_scrambled[0..63].
- State:
  - 128-bit buffer buf; cnt[7:0] = number of valid bits, range 0..128.
  - Valid bits always occupy buf[cnt-1:0], oldest at bit 0.
- Per cycle (combinational decisions):
  - emit = (cnt >= 32).
  - rem = cnt - (emit ? 32 : 0).
  - in_ready = (rem <= 62).
  - accept = in_valid & in_ready.
- Clock edge:
  - buf <= (emit ? buf >> 32 : buf), with B written at bit position rem when accept.
  - cnt <= rem + (accept ? 66 : 0).
  - out_data <= buf[31:0] when emit; otherwise out_data is held.
  - out_valid <= emit.
- Latency:
  - A block accepted at edge N into an empty gearbox produces its first word on out_data/out_valid after edge N+1.
  - All 66 bits have left after edge N+3, with the two trailing bits carried into the next word.
- Invariant: cnt never exceeds 128; bits are never dropped, duplicated or reordered.
- Throughput: with in_valid held high, out_valid stays high every cycle after the second edge, and exactly 16 blocks are accepted per 33 output words in the long run.
- Underrun:
  - If in_valid is low and cnt < 32, out_valid drops to 0 and out_data holds its last value.
  - Residual bits (< 32) stay buffered until more input arrives; no padding is inserted.
- Header check:
  - On accept with sync_hdr == 2'b00 or 2'b11, hdr_err_cnt increments and saturates at all-ones.
  - The block is still passed through unchanged.
- Simultaneous emit and accept in one cycle is the normal case; the shift is applied before the insert, as defined above.
- Reset (including mid-block):
  - buf = 0, cnt = 0, out_data = 0, out_valid = 0, hdr_err_cnt = 0.
  - in_ready reads 1 while reset is asserted.
  - Any partially sent block is discarded; the first block after reset starts a new word at bit 0.
- in_valid is ignored while in_ready = 0. The upstream holds its block; no skid storage exists here.

Test Plan:
- Single block, empty gearbox:
  - Stimulus: sync_hdr=2'b01, data=64'h0, one cycle of in_valid, then idle.
  - Response: one word 32'h0000_0001, then a second word 32'h0000_0000, then out_valid=0 with cnt=2 residual.
  - A following block with sync_hdr=2'b10, data=all-ones yields next word 32'hFFFF_FFF8.
- Streaming:
  - Stimulus: in_valid held high for 528 cycles, data = incrementing 64-bit counter, sync_hdr alternating 01/10.
  - Response: out_valid continuously high from cycle 2; 256±1 blocks accepted; a reference deserializer reproduces the exact block sequence.
- Backpressure:
  - Starting from reset with continuous in_valid, in_ready must read 1,1,0,1,0,1,... on cycles 0..5.
  - The first double-0 gap occurs when rem reaches 64.
  - A block held during in_ready=0 is accepted exactly once.
- Header errors:
  - Stimulus: 3 blocks with sync_hdr=2'b00 and 2 with 2'b11, interleaved with legal ones.
  - Response: hdr_err_cnt=5 and the payload is unaltered.
  - With ERR_CNT_W=2, the counter saturates at 3.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) while cnt=100.
  - Response: out_valid/out_data/hdr_err_cnt go to 0 immediately.
  - After release, a block 01/64'h0 produces 32'h0000_0001 as its first word.
- Underrun recovery:
  - Stimulus: in_valid drops for 5 cycles mid-stream.
  - Response: out_valid goes low once cnt < 32, then resumes without bit loss (checked against the reference deserializer).
